// File: rtl/oddr_pattern_sequencer.sv
// Frame sequencer for the ODDR test pin: preamble, data burst, gap, optional repeat.
// Produces registered per-cycle rising/falling-edge bits and the tristate enable.
module oddr_pattern_sequencer #(
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned PREAMBLE_CYCLES = 4,
    parameter int unsigned PATTERN_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [CNT_W-1:0]     burst_len,
    input  logic [CNT_W-1:0]     gap_len,
    input  logic                 repeat_en,
    input  logic [PATTERN_W-1:0] user_pattern,
    output logic                 oddr_d1,
    output logic                 oddr_d2,
    output logic                 oddr_oe,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     burst_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_BURST = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]           state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [1:0]           mode_q;
    logic [CNT_W-1:0]     len_q, gap_q;
    logic                 rep_q;
    logic [PATTERN_W-1:0] pat_q;
    logic [6:0]           lfsr;
    logic                 take, bump, to_burst, end_burst, fire;
    logic                 prbs_b1, prbs_b2;
    logic                 d1_n, d2_n;

    // Two x^7+x^6+1 steps per cycle: first new bit, then second.
    assign prbs_b1 = lfsr[6] ^ lfsr[5];
    assign prbs_b2 = lfsr[5] ^ lfsr[4];
    assign fire    = (state_n == S_BURST);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        take      = 1'b0;
        bump      = 1'b0;
        to_burst  = 1'b0;
        end_burst = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && enable) begin
                    take    = 1'b1;
                    state_n = S_PRE;
                    cnt_n   = CNT_W'(PREAMBLE_CYCLES - 1);
                end
            end
            S_PRE: begin
                if (cnt == '0) to_burst = 1'b1;
                else           cnt_n = cnt - CNT_W'(1);
            end
            S_BURST: begin
                if (cnt == '0) end_burst = 1'b1;
                else           cnt_n = cnt - CNT_W'(1);
            end
            S_GAP: begin
                if (cnt != '0)  cnt_n = cnt - CNT_W'(1);
                else if (rep_q) to_burst = 1'b1;
                else            state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if (to_burst) begin
            if (len_q != '0) begin
                state_n = S_BURST;
                cnt_n   = len_q - CNT_W'(1);
            end else begin
                end_burst = 1'b1;
            end
        end

        // Zero-length burst with zero gap in repeat mode spends one gap cycle per
        // counted burst so the loop always advances in time.
        if (end_burst) begin
            bump = 1'b1;
            if (gap_q != '0) begin
                state_n = S_GAP;
                cnt_n   = gap_q - CNT_W'(1);
            end else if (rep_q && len_q != '0) begin
                state_n = S_BURST;
                cnt_n   = len_q - CNT_W'(1);
            end else if (rep_q) begin
                state_n = S_GAP;
                cnt_n   = '0;
            end else begin
                state_n = S_DONE;
            end
        end

        if (state != S_IDLE && !enable) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            bump    = 1'b0;
        end
    end

    always_comb begin
        d1_n = 1'b0;
        d2_n = 1'b0;
        if (fire) begin
            case (mode_q)
                2'd0: d1_n = 1'b1;
                2'd1: begin
                    d1_n = prbs_b1;
                    d2_n = prbs_b2;
                end
                2'd2: begin
                    d1_n = pat_q[0];
                    d2_n = pat_q[1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mode_q      <= 2'd0;
            len_q       <= '0;
            gap_q       <= '0;
            rep_q       <= 1'b0;
            pat_q       <= '0;
            lfsr        <= 7'h7F;
            burst_count <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (take) begin
                mode_q      <= mode;
                len_q       <= burst_len;
                gap_q       <= gap_len;
                rep_q       <= repeat_en;
                pat_q       <= user_pattern;
                lfsr        <= 7'h7F;
                burst_count <= '0;
            end else begin
                if (fire) begin
                    lfsr  <= {lfsr[4:0], prbs_b1, prbs_b2};
                    // Rotating copy keeps the current bit pair at [1:0].
                    pat_q <= PATTERN_W'({pat_q[1:0], pat_q} >> 2);
                end
                if (bump) burst_count <= burst_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oddr_d1 <= 1'b0;
            oddr_d2 <= 1'b0;
            oddr_oe <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            oddr_d1 <= d1_n;
            oddr_d2 <= d2_n;
            oddr_oe <= (state_n == S_PRE) || (state_n == S_BURST) || (state_n == S_GAP);
            busy    <= (state_n != S_IDLE);
            done    <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_oddr_pattern_sequencer.sv
// Directed bench for oddr_pattern_sequencer with hand-computed frame vectors.
module tb_oddr_pattern_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] burst_len;
    logic [15:0] gap_len;
    logic        repeat_en;
    logic [7:0]  user_pattern;
    logic        oddr_d1, oddr_d2, oddr_oe, busy, done;
    logic [15:0] burst_count;

    int checks = 0;
    int passed = 0;

    // {busy, oe, d1, d2, done} for mode 0, len 3, gap 2, no repeat
    logic [4:0] m0_exp [0:9] = '{5'b11000, 5'b11000, 5'b11000, 5'b11000,
                                 5'b11100, 5'b11100, 5'b11100,
                                 5'b11000, 5'b11000, 5'b10001};
    // {d1, d2} for user_pattern 8'b1011_0010
    logic [1:0] m2_exp [0:5] = '{2'b01, 2'b00, 2'b11, 2'b01, 2'b01, 2'b00};
    // {d1, d2} for PRBS7 seeded 7'h7F
    logic [1:0] m1_exp [0:3] = '{2'b00, 2'b00, 2'b00, 2'b10};

    oddr_pattern_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .start        (start),
        .mode         (mode),
        .burst_len    (burst_len),
        .gap_len      (gap_len),
        .repeat_en    (repeat_en),
        .user_pattern (user_pattern),
        .oddr_d1      (oddr_d1),
        .oddr_d2      (oddr_d2),
        .oddr_oe      (oddr_oe),
        .busy         (busy),
        .done         (done),
        .burst_count  (burst_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [1:0] m, input logic [15:0] len,
                               input logic [15:0] gap, input logic rep,
                               input logic [7:0] pat);
        mode = m; burst_len = len; gap_len = gap; repeat_en = rep; user_pattern = pat;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_m0_frame(input string tag);
        start_frame(2'd0, 16'd3, 16'd2, 1'b0, 8'h00);
        for (int c = 0; c < 10; c++) begin
            if (c != 0) tick();
            check($sformatf("%s cyc%0d", tag, c + 1),
                  {busy, oddr_oe, oddr_d1, oddr_d2, done}, m0_exp[c]);
        end
        tick();
        check({tag, " idle"}, {busy, oddr_oe, done}, 3'b000);
        check({tag, " count"}, burst_count, 1);
    endtask

    task automatic run_prbs(input string tag);
        start_frame(2'd1, 16'd4, 16'd0, 1'b0, 8'h00);
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("%s bit%0d", tag, i), {oddr_oe, oddr_d1, oddr_d2}, {1'b1, m1_exp[i]});
        end
        tick();
        check({tag, " done"}, done, 1);
        tick();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; start = 1'b0; mode = 2'd0;
        burst_len = '0; gap_len = '0; repeat_en = 1'b0; user_pattern = '0;
        repeat (2) tick();
        check("reset outs", {busy, oddr_oe, oddr_d1, oddr_d2, done}, 5'b00000);
        check("reset count", burst_count, 0);
        rst = 1'b0;
        tick();

        run_m0_frame("m0");

        // user pattern; mid-frame input changes must not matter
        start_frame(2'd2, 16'd6, 16'd0, 1'b0, 8'b1011_0010);
        user_pattern = 8'h00; mode = 2'd0; burst_len = 16'd1;
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("m2 pair%0d", i), {oddr_oe, oddr_d1, oddr_d2}, {1'b1, m2_exp[i]});
        end
        tick();
        check("m2 done", {done, oddr_oe}, 2'b10);
        tick();

        run_prbs("prbs a");
        run_prbs("prbs b");

        // repeat with no gap, abort after five bursts
        start_frame(2'd0, 16'd2, 16'd0, 1'b1, 8'h00);
        repeat (3) tick();
        for (int c = 5; c <= 15; c++) begin
            tick();
            check($sformatf("rep cyc%0d", c), {oddr_oe, oddr_d1, oddr_d2, done}, 4'b1100);
        end
        check("rep count5", burst_count, 5);
        enable = 1'b0;
        tick();
        check("abort outs", {busy, oddr_oe, oddr_d1, oddr_d2, done}, 5'b00000);
        check("abort count", burst_count, 5);
        tick();
        check("abort no done", done, 0);
        enable = 1'b1;

        // zero burst, zero gap; second start while busy is ignored
        start_frame(2'd0, 16'd0, 16'd0, 1'b0, 8'h00);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("skip pre4", {busy, oddr_oe, oddr_d1, oddr_d2, done}, 5'b11000);
        tick();
        check("skip done", {busy, oddr_oe, done}, 3'b101);
        check("skip count", burst_count, 1);
        tick();
        check("skip idle", busy, 0);
        tick();
        check("busy start ignored", busy, 0);

        // start with enable low is not accepted
        enable = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; enable = 1'b1;
        tick();
        check("start no enable", busy, 0);

        // async reset mid-burst
        start_frame(2'd0, 16'd5, 16'd0, 1'b0, 8'h00);
        repeat (4) tick();
        check("pre-rst burst", {oddr_oe, oddr_d1, oddr_d2}, 3'b110);
        #2 rst = 1'b1;
        #1;
        check("async rst outs", {busy, oddr_oe, oddr_d1, oddr_d2, done}, 5'b00000);
        check("async rst count", burst_count, 0);
        #2 rst = 1'b0;
        tick();
        run_m0_frame("post-rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
